// File: rtl/lifo_stack.sv
// Parameterised LIFO data stack with peek/poke addressed by depth from the top.
// Read data is registered; depth/full/empty decode combinationally from the count.
module lifo_stack #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 8,
    localparam int IW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_en,
    input  logic             pop_en,
    input  logic             peek_en,
    input  logic             poke_en,
    input  logic [IW-1:0]    index,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [IW-1:0]    depth
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    count;
    logic [AW-1:0]    push_addr;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    idx_addr;
    logic             idx_hit;
    logic             do_push;
    logic             do_poke;

    assign depth = count;
    assign full  = (count == IW'(DEPTH));
    assign empty = (count == '0);

    // Index i maps to mem[count-1-i]; only meaningful when i < count.
    assign push_addr = AW'(count);
    assign top_addr  = AW'(count - IW'(1));
    assign idx_addr  = AW'(count - index - IW'(1));
    assign idx_hit   = (index < count);

    assign do_push = push_en && !full;
    assign do_poke = !push_en && !pop_en && poke_en && idx_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            data_out <= '0;
        end else if (push_en) begin
            if (!full) begin
                count <= count + IW'(1);
            end
        end else if (pop_en) begin
            if (!empty) begin
                data_out <= mem[top_addr];
                count    <= count - IW'(1);
            end
        end else if (poke_en) begin
            data_out <= data_out;
        end else if (peek_en) begin
            data_out <= idx_hit ? mem[idx_addr] : '0;
        end
    end

    // Storage is not reset; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[push_addr] <= data_in;
        end else if (do_poke) begin
            mem[idx_addr] <= data_in;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack with hand-computed expectations.
module tb_lifo_stack;

    localparam int WIDTH = 56;
    localparam int DEPTH = 8;
    localparam int IW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             push_en;
    logic             pop_en;
    logic             peek_en;
    logic             poke_en;
    logic [IW-1:0]    index;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [IW-1:0]    depth;

    int checks = 0;
    int errors = 0;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_en  (push_en),
        .pop_en   (pop_en),
        .peek_en  (peek_en),
        .poke_en  (poke_en),
        .index    (index),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .depth    (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Apply one command for one clock edge, then return 1ns after that edge.
    task automatic cmd(input logic pu, input logic po, input logic pe, input logic pk,
                       input logic [IW-1:0] idx, input logic [WIDTH-1:0] d);
        push_en = pu;
        pop_en  = po;
        peek_en = pe;
        poke_en = pk;
        index   = idx;
        data_in = d;
        @(posedge clk);
        #1;
        push_en = 1'b0;
        pop_en  = 1'b0;
        peek_en = 1'b0;
        poke_en = 1'b0;
        index   = '0;
        data_in = '0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, '0, d);
    endtask

    task automatic pop();
        cmd(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic peek(input logic [IW-1:0] idx);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, idx, '0);
    endtask

    task automatic poke(input logic [IW-1:0] idx, input logic [WIDTH-1:0] d);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, idx, d);
    endtask

    initial begin
        rst_n   = 1'b0;
        push_en = 1'b0;
        pop_en  = 1'b0;
        peek_en = 1'b0;
        poke_en = 1'b0;
        index   = '0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_depth", 64'(depth), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        rst_n = 1'b1;

        push(56'h11);
        push(56'h22);
        push(56'h33);
        check("push3_depth", 64'(depth), 64'd3);
        check("push3_empty", 64'(empty), 64'd0);
        check("push3_full", 64'(full), 64'd0);
        peek(0);
        check("peek0", 64'(data_out), 64'h33);
        peek(1);
        check("peek1", 64'(data_out), 64'h22);
        peek(2);
        check("peek2", 64'(data_out), 64'h11);
        peek(3);
        check("peek_oob", 64'(data_out), 64'h0);

        pop();
        check("pop1_data", 64'(data_out), 64'h33);
        check("pop1_depth", 64'(depth), 64'd2);
        pop();
        check("pop2_data", 64'(data_out), 64'h22);
        check("pop2_depth", 64'(depth), 64'd1);
        pop();
        check("pop3_data", 64'(data_out), 64'h11);
        check("pop3_empty", 64'(empty), 64'd1);
        pop();
        check("pop_empty_data", 64'(data_out), 64'h11);
        check("pop_empty_depth", 64'(depth), 64'd0);

        for (int i = 1; i <= 8; i++) push(WIDTH'(i));
        check("fill_full", 64'(full), 64'd1);
        check("fill_depth", 64'(depth), 64'd8);
        push(56'd9);
        check("overflow_depth", 64'(depth), 64'd8);
        peek(0);
        check("overflow_peek0", 64'(data_out), 64'd8);
        peek(7);
        check("bottom_peek7", 64'(data_out), 64'd1);

        // Asynchronous reset mid-cycle, observed before any clock edge.
        rst_n = 1'b0;
        #2;
        check("async_rst_depth", 64'(depth), 64'd0);
        check("async_rst_empty", 64'(empty), 64'd1);
        check("async_rst_data_out", 64'(data_out), 64'd0);
        #1;
        rst_n = 1'b1;

        push(56'd10);
        push(56'd20);
        push(56'd30);
        poke(1, 56'd99);
        peek(1);
        check("poke_peek1", 64'(data_out), 64'd99);
        peek(0);
        check("poke_peek0", 64'(data_out), 64'd30);
        check("poke_depth", 64'(depth), 64'd3);
        poke(3, 56'd55);
        check("poke_oob_depth", 64'(depth), 64'd3);
        peek(3);
        check("poke_oob_peek3", 64'(data_out), 64'd0);
        peek(2);
        check("poke_oob_bottom", 64'(data_out), 64'd10);

        poke(0, 56'hFEDCBA98765432);
        check("poke_keeps_data_out", 64'(data_out), 64'd10);
        peek(0);
        check("wide_poke_peek0", 64'(data_out), 64'hFEDCBA98765432);

        // Priority: push beats pop.
        cmd(1'b1, 1'b1, 1'b0, 1'b0, '0, 56'd7);
        check("pushpop_depth", 64'(depth), 64'd4);
        check("pushpop_data_out", 64'(data_out), 64'hFEDCBA98765432);
        peek(0);
        check("pushpop_peek0", 64'(data_out), 64'd7);

        // Pop beats peek.
        cmd(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, '0);
        check("poppeek_data", 64'(data_out), 64'd7);
        check("poppeek_depth", 64'(depth), 64'd3);

        // Poke beats peek; data_out holds.
        cmd(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 56'd44);
        check("pokepeek_data_out", 64'(data_out), 64'd7);
        peek(1);
        check("pokepeek_written", 64'(data_out), 64'd44);

        cmd(1'b0, 1'b0, 1'b0, 1'b0, '0, 56'd123);
        check("idle_hold_data", 64'(data_out), 64'd44);
        check("idle_hold_depth", 64'(depth), 64'd3);

        // A push coinciding with reset is discarded.
        push_en = 1'b1;
        data_in = 56'd66;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        push_en = 1'b0;
        data_in = '0;
        check("rst_inflight_depth", 64'(depth), 64'd0);
        rst_n = 1'b1;
        push(56'hAB);
        check("post_rst_depth", 64'(depth), 64'd1);
        peek(0);
        check("post_rst_peek0", 64'(data_out), 64'hAB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parameterised LIFO data stack with random-access peek and poke relative to the top of stack. It serves as the per-core data stack of the CPU7 core: the core pushes constants and results, pops operands, and reads or overwrites arbitrary entries by depth index. All accesses are single-cycle commands. Read data is registered, and status outputs are combinational from the item count.

## Interface
- WIDTH, default 56: data word width in bits.
- DEPTH, default 8: maximum item count; must be at least 2.
- IW: local, $clog2(DEPTH)+1 bits. This is the width of index and depth, so a full count is representable.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- push_en  input  1  push data_in onto the top.
- pop_en  input  1  remove the top item and return it on data_out.
- peek_en  input  1  return the item at index on data_out; no state change.
- poke_en  input  1  replace the item at index with data_in.
- index  input  IW  element index; 0 is the top, depth-1 is the bottom.
- data_in  input  WIDTH  data for push or poke.
- data_out  output  WIDTH  registered result of the last pop or peek.
- full  output  1  high when count equals DEPTH.
- empty  output  1  high when count is 0.
- depth  output  IW  current item count.

## Operation
- Storage is mem[0..DEPTH-1] plus a count register. Bottom item is mem[0]; top item is mem[count-1]. Element at index i is mem[count-1-i].
- At most one command executes per cycle. If several enables are high, priority is push > pop > poke > peek. Lower-priority commands in that cycle are ignored.
- Push, when not full: mem[count] <= data_in; count increments.
- Push when full: ignored; memory and count are unchanged. The caller is responsible for checking full, and the core raises its own error.
- Pop, when not empty: data_out <= mem[count-1]; count decrements. The vacated slot does not need to be cleared.
- Pop when empty: ignored; count and data_out are unchanged.
- Peek with index < count: data_out <= mem[count-1-index].
- Peek with index >= count: data_out <= 0.
- Poke with index < count: mem[count-1-index] <= data_in; count and data_out are unchanged.
- Poke with index >= count: ignored.
- With no enable asserted, all state holds, including data_out.
- depth = count. full = (count == DEPTH). empty = (count == 0). All three are purely combinational from count.
- Reset (rst_n low, asynchronous): count <= 0 and data_out <= 0. Memory contents are don't-care.
  - The core uses rst_n mid-operation as an "empty stack" command. Any command in flight on the reset edge is discarded.
  - After reset: full=0, empty=1, depth=0.

## Timing
- Commands are sampled on the rising clk edge. There is no handshake or back-pressure; every command completes in 1 cycle.
- Pop or peek issued at edge N: data_out is valid after edge N and stays stable until the next pop, peek or reset.
- depth, full and empty reflect a push or pop immediately after the edge on which it executes.
- Back-to-back commands on consecutive cycles are supported.
  - Example: a peek in the cycle right after a push sees the new top at index 0.
- Reset asserts asynchronously and deasserts synchronously with clk. The first command is accepted on the first edge with rst_n high.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 -> depth=3, empty=0, full=0. Peek index 0, 1, 2 -> data_out = 0x33, 0x22, 0x11, each one cycle after the peek.
- Push 8 values 1..8 with DEPTH=8 -> full=1, depth=8. A 9th push of 9 is ignored: depth stays 8 and peek 0 returns 8.
- From [1,2,3] (top 3): pop -> data_out=3, depth=2. Pop -> data_out=2, depth=1. Pop -> data_out=1, empty=1. A further pop leaves data_out=1 and depth=0.
- From [10,20,30] (top 30): poke index 1 with 99, then peek 1 -> 99. Peek 0 -> 30 and depth stays 3. Poke index 3 is ignored; peek index 3 -> 0.
- Push and pop asserted together on [5] with data_in=7 -> push wins: depth=2, peek 0 returns 7, data_out unchanged.
- From depth 4, pulse rst_n low mid-cycle -> depth=0, empty=1, data_out=0 without waiting for a clk edge. Then push 0xAB -> depth=1, and peek 0 returns 0xAB.
